// File: rtl/data_memory_ctrl.sv
// Byte-addressable data memory for the 16-bit core: valid/ready requests, byte/word access,
// registered load data with a valid strobe, fault reporting and a post-reset clear sequence.
module data_memory_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MEMORY_REQ_VALID,
  output logic                  MEMORY_REQ_READY,
  input  logic                  MEMORY_WRITE_ENABLE,
  input  logic                  MEMORY_ACCESS_SIZE,
  input  logic                  MEMORY_READ_SIGNED,
  input  logic [ADDR_WIDTH-1:0] MEMORY_ACCESS_ADDR,
  input  logic [DATA_WIDTH-1:0] MEMORY_WRITE_DATA,
  output logic [DATA_WIDTH-1:0] MEMORY_READ_DATA,
  output logic                  MEMORY_READ_VALID,
  output logic                  MEMORY_ERROR,
  output logic                  MEMORY_INIT_DONE
);

  localparam int L  = DATA_WIDTH / 8;
  localparam int LB = $clog2(L);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One bit wider than the address so a span of 2**ADDR_WIDTH cannot wrap to zero
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH + 1)'(DEPTH * L);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  state_t                state_r;
  logic [IW-1:0]         ptr_r;
  logic                  ready_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic                  rvalid_r;
  logic                  err_r;
  logic                  done_r;
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  logic                  accept_s;
  logic [LB-1:0]         lane_s;
  logic [IW-1:0]         idx_s;
  logic                  oor_s;
  logic                  misal_s;
  logic                  fault_s;
  logic [DATA_WIDTH-1:0] rd_word_s;
  logic [7:0]            rd_byte_s;
  logic [DATA_WIDTH-1:0] load_data_s;
  logic [DATA_WIDTH-1:0] merge_s;
  logic                  wr_en_s;
  logic [IW-1:0]         wr_idx_s;
  logic [DATA_WIDTH-1:0] wr_data_s;

  assign MEMORY_REQ_READY  = ready_r;
  assign MEMORY_READ_DATA  = rdata_r;
  assign MEMORY_READ_VALID = rvalid_r;
  assign MEMORY_ERROR      = err_r;
  assign MEMORY_INIT_DONE  = done_r;

  // Request decode: word/lane split, fault detection and addressed-word read
  always_comb begin
    accept_s  = MEMORY_REQ_VALID & ready_r;
    lane_s    = MEMORY_ACCESS_ADDR[LB-1:0];
    idx_s     = MEMORY_ACCESS_ADDR[LB +: IW];
    oor_s     = ({1'b0, MEMORY_ACCESS_ADDR} >= SPAN);
    misal_s   = MEMORY_ACCESS_SIZE & (lane_s != {LB{1'b0}});
    fault_s   = oor_s | misal_s;
    rd_word_s = mem_r[idx_s];
    rd_byte_s = 8'h00;
    merge_s   = rd_word_s;
    for (int i = 0; i < L; i++) begin
      rd_byte_s = rd_byte_s | ((lane_s == LB'(i)) ? rd_word_s[i*8 +: 8] : 8'h00);
      merge_s[i*8 +: 8] = (lane_s == LB'(i)) ? MEMORY_WRITE_DATA[7:0] : rd_word_s[i*8 +: 8];
    end
    if (MEMORY_ACCESS_SIZE) begin
      load_data_s = rd_word_s;
    end else begin
      load_data_s = {{(DATA_WIDTH-8){MEMORY_READ_SIGNED & rd_byte_s[7]}}, rd_byte_s};
    end
  end

  // Array write port: clear pointer during INIT, otherwise accepted non-faulted stores
  always_comb begin
    if (state_r == ST_INIT) begin
      wr_en_s   = 1'b1;
      wr_idx_s  = ptr_r;
      wr_data_s = {DATA_WIDTH{1'b0}};
    end else begin
      wr_en_s   = accept_s & MEMORY_WRITE_ENABLE & ~fault_s;
      wr_idx_s  = idx_s;
      wr_data_s = MEMORY_ACCESS_SIZE ? MEMORY_WRITE_DATA : merge_s;
    end
  end

  // Memory array update
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_idx_s] <= wr_data_s;
    end
  end

  // Control FSM with registered handshake, load result and fault pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_INIT;
      ptr_r    <= {IW{1'b0}};
      ready_r  <= 1'b0;
      rdata_r  <= {DATA_WIDTH{1'b0}};
      rvalid_r <= 1'b0;
      err_r    <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          rvalid_r <= 1'b0;
          err_r    <= 1'b0;
          ptr_r    <= ptr_r + IW'(1);
          if (ptr_r == IW'(DEPTH - 1)) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
            done_r  <= 1'b1;
          end
        end
        ST_IDLE: begin
          rvalid_r <= accept_s & ~MEMORY_WRITE_ENABLE;
          err_r    <= accept_s & fault_s;
          if (accept_s && !MEMORY_WRITE_ENABLE) begin
            rdata_r <= fault_s ? {DATA_WIDTH{1'b0}} : load_data_s;
          end
        end
        default: begin
          state_r <= ST_INIT;
          ptr_r   <= {IW{1'b0}};
          ready_r <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: clear sequence, table-driven byte/word/fault vectors,
// back-to-back streaming and asynchronous reset corner cases.
module tb_data_memory_ctrl;

  localparam int DEPTH = 32;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        we;
  logic        sz;
  logic        sg;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        rvalid;
  logic        err;
  logic        done;

  int total_cnt;
  int pass_cnt;

  typedef struct {
    logic        req;
    logic        we;
    logic        sz;
    logic        sg;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        ev;
    logic        ee;
    logic [15:0] ed;
  } vec_t;

  vec_t vecs[19];

  data_memory_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .MEMORY_REQ_VALID    (req_valid),
    .MEMORY_REQ_READY    (req_ready),
    .MEMORY_WRITE_ENABLE (we),
    .MEMORY_ACCESS_SIZE  (sz),
    .MEMORY_READ_SIGNED  (sg),
    .MEMORY_ACCESS_ADDR  (addr),
    .MEMORY_WRITE_DATA   (wdata),
    .MEMORY_READ_DATA    (rdata),
    .MEMORY_READ_VALID   (rvalid),
    .MEMORY_ERROR        (err),
    .MEMORY_INIT_DONE    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one request, let the edge pass and settle just after it
  task automatic step(input logic r, input logic w, input logic s, input logic g,
                      input logic [15:0] a, input logic [15:0] d);
    req_valid = r; we = w; sz = s; sg = g; addr = a; wdata = d;
    @(posedge clk);
    #1;
  endtask

  // Caller has just released rst; READY/INIT_DONE must stay low for exactly DEPTH edges
  task automatic init_check(input string nm);
    logic low_ok;
    low_ok = 1'b1;
    for (int c = 1; c <= DEPTH; c++) begin
      @(posedge clk);
      #1;
      if (c < DEPTH && (req_ready !== 1'b0 || done !== 1'b0)) low_ok = 1'b0;
    end
    chk({nm, "_low_phase"}, {15'd0, low_ok}, 16'd1);
    chk({nm, "_ready"}, {15'd0, req_ready}, 16'd1);
    chk({nm, "_done"}, {15'd0, done}, 16'd1);
    req_valid = 1'b0;
  endtask

  task automatic zero_sweep(input string nm);
    for (int k = 0; k < DEPTH; k++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 16'(2 * k), 16'h0000);
      chk({nm, "_valid"}, {15'd0, rvalid}, 16'd1);
      chk({nm, "_err"}, {15'd0, err}, 16'd0);
      chk({nm, "_data"}, rdata, 16'h0000);
    end
    req_valid = 1'b0;
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    clk = 1'b0;
    rst = 1'b1;
    req_valid = 1'b0; we = 1'b0; sz = 1'b0; sg = 1'b0; addr = 16'h0000; wdata = 16'h0000;

    //          req   we    sz    sg    addr      wdata     ev    ee    ed
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0004, 16'h1234, 1'b0, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0004, 16'h0000, 1'b1, 1'b0, 16'h1234};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0005, 16'h77AB, 1'b0, 1'b0, 16'h1234};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0004, 16'h0000, 1'b1, 1'b0, 16'hAB34};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0005, 16'h0000, 1'b1, 1'b0, 16'hFFAB};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0005, 16'h0000, 1'b1, 1'b0, 16'h00AB};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0004, 16'h0000, 1'b1, 1'b0, 16'h0034};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0003, 16'hBEEF, 1'b0, 1'b1, 16'h0034};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b1, 1'b0, 16'h0000};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1, 1'b1, 16'h0000};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h003F, 16'h0080, 1'b0, 1'b0, 16'h0000};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h003F, 16'h0000, 1'b1, 1'b0, 16'hFF80};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h003F, 16'h0000, 1'b1, 1'b0, 16'h0080};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0042, 16'h5555, 1'b0, 1'b1, 16'h0080};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b1, 1'b0, 16'h0000};
    vecs[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFE, 16'h0000, 1'b1, 1'b1, 16'h0000};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0041, 16'h0000, 1'b1, 1'b1, 16'h0000};
    vecs[17] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0004, 16'h0000, 1'b1, 1'b0, 16'hAB34};
    vecs[18] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0004, 16'hFFFF, 1'b0, 1'b0, 16'hAB34};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {15'd0, req_ready}, 16'd0);
    chk("reset_rdata", rdata, 16'h0000);
    chk("reset_rvalid", {15'd0, rvalid}, 16'd0);
    chk("reset_err", {15'd0, err}, 16'd0);
    chk("reset_done", {15'd0, done}, 16'd0);

    // A store offered throughout the clear must be ignored
    req_valid = 1'b1; we = 1'b1; sz = 1'b1; addr = 16'h0000; wdata = 16'hFFFF;
    rst = 1'b0;
    init_check("init1");
    zero_sweep("zero1");

    for (int i = 0; i < 19; i++) begin
      step(vecs[i].req, vecs[i].we, vecs[i].sz, vecs[i].sg, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("vec%0d_valid", i), {15'd0, rvalid}, {15'd0, vecs[i].ev});
      chk($sformatf("vec%0d_err", i), {15'd0, err}, {15'd0, vecs[i].ee});
      chk($sformatf("vec%0d_data", i), rdata, vecs[i].ed);
    end

    // Streaming: 32 back-to-back stores then 32 back-to-back loads
    for (int k = 0; k < DEPTH; k++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 16'(2 * k), 16'(k + 1));
    end
    for (int k = 0; k < DEPTH; k++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 16'(2 * k), 16'h0000);
      chk($sformatf("stream%0d_valid", k), {15'd0, rvalid}, 16'd1);
      chk($sformatf("stream%0d_data", k), rdata, 16'(k + 1));
    end
    req_valid = 1'b0;

    // Reset from IDLE, then again 10 cycles into the clear
    rst = 1'b1;
    #1;
    chk("rst_idle_ready", {15'd0, req_ready}, 16'd0);
    chk("rst_idle_done", {15'd0, done}, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    chk("rst_init_ready", {15'd0, req_ready}, 16'd0);
    chk("rst_init_done", {15'd0, done}, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    init_check("init2");

    // Reset landing on the edge that accepts a load
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0004, 16'h1234);
    req_valid = 1'b1; we = 1'b0; sz = 1'b1; addr = 16'h0004;
    @(posedge clk);
    rst = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("rst_load_rvalid", {15'd0, rvalid}, 16'd0);
    chk("rst_load_err", {15'd0, err}, 16'd0);
    chk("rst_load_rdata", rdata, 16'h0000);
    chk("rst_load_ready", {15'd0, req_ready}, 16'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    init_check("init3");
    zero_sweep("zero3");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
Parametrised, byte-addressable data memory for the 16-bit RISC core, replacing the fixed-size DATA_MEMORY.
- Adds a valid/ready request handshake, byte and word access with byte-lane writes, and sign/zero-extended byte reads.
- Read data is registered with a valid strobe; misaligned or out-of-range accesses raise an error.
- A post-reset clear FSM zeroes every word before the first request is accepted.
- Sits between the core's load/store stage and the memory array.

Parameters:
DATA_WIDTH, 16, word width in bits; power of two, >=16, multiple of 8
ADDR_WIDTH, 16, byte-address width
DEPTH, 32, number of words; power of two; byte span = DEPTH*DATA_WIDTH/8

Ports:
clk  input  1  single clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
MEMORY_REQ_VALID  input  1  request present
MEMORY_REQ_READY  output  1  block can accept a request this cycle
MEMORY_WRITE_ENABLE  input  1  1 = store, 0 = load (sampled with the request)
MEMORY_ACCESS_SIZE  input  1  0 = byte, 1 = full word
MEMORY_READ_SIGNED  input  1  byte loads: 1 = sign-extend, 0 = zero-extend
MEMORY_ACCESS_ADDR  input  ADDR_WIDTH  byte address
MEMORY_WRITE_DATA  input  DATA_WIDTH  store data; byte stores use bits [7:0]
MEMORY_READ_DATA  output  DATA_WIDTH  registered load result
MEMORY_READ_VALID  output  1  one-cycle pulse; MEMORY_READ_DATA is valid
MEMORY_ERROR  output  1  one-cycle pulse for a faulted access
MEMORY_INIT_DONE  output  1  high once the clear sequence has completed

Behaviour:
- Reset values (asynchronous): READY=0, READ_DATA=0, READ_VALID=0, ERROR=0, INIT_DONE=0. FSM goes to INIT with clear pointer = 0.
- FSM states:
  - INIT: writes 0 to word[ptr] each cycle and increments ptr. READY stays 0. After ptr=DEPTH-1 is written, the next state is IDLE and INIT_DONE is set. The sequence takes exactly DEPTH cycles after rst deasserts.
  - IDLE: READY=1 constantly. There is no busy state, so back-to-back requests are accepted every cycle.
- A request is accepted on a rising edge where VALID && READY.
- Addressing:
  - Lanes per word L = DATA_WIDTH/8.
  - Word index = ADDR >> log2(L); lane = ADDR[log2(L)-1:0].
  - Little-endian: lane 0 = bits [7:0].
- Fault conditions:
  - Word access with lane != 0 is misaligned.
  - Word index >= DEPTH, or ADDR >= DEPTH*L, is out of range.
  - A faulted access writes nothing. ERROR pulses in the cycle after acceptance.
  - A faulted load also pulses READ_VALID with READ_DATA=0.
- Store: the memory is updated at the accepting edge.
  - Word store writes all lanes.
  - Byte store writes only the addressed lane with WRITE_DATA[7:0]; other lanes are unchanged.
  - No READ_VALID is produced for a store.
- Load: latency 1. READ_DATA and READ_VALID are registered at the accepting edge and visible for exactly one cycle.
  - Word load returns the full word.
  - Byte load returns the addressed lane, extended per READ_SIGNED.
  - READ_DATA holds its last value when READ_VALID=0.
- Store-then-load: a load accepted in the cycle after a store to the same word returns the new data. Loads always observe every earlier-accepted store.
- Requests while READY=0 are ignored. They cause no state change and no error.
- Reset mid-operation (any state): asynchronous return to INIT. Any pending READ_VALID/ERROR pulse is dropped. The clear restarts from ptr=0.
- The address comparison must be done at ADDR_WIDTH width; no truncation-induced aliasing is allowed.

Test Plan:
- Init:
  - Deassert rst → READY=0 and INIT_DONE=0 for exactly 32 cycles, then both 1.
  - Word loads of addresses 0..62 step 2 all return 0x0000.
- Word round-trip:
  - Store 0x1234 @4, then load @4 on the next cycle → READ_VALID one cycle later, READ_DATA=0x1234, ERROR=0.
  - 32 consecutive stores (addr 0,2,…,62, data 1..32), then 32 loads back-to-back → data 1..32 in order, one per cycle.
- Byte lanes:
  - After 0x1234 @4, byte-store 0xAB @5 → word load @4 returns 0xAB34.
  - Byte load @5 with SIGNED=1 → 0xFFAB; with SIGNED=0 → 0x00AB.
  - Byte load @4 with SIGNED=1 → 0x0034.
- Faults:
  - Word store 0xBEEF @3 → ERROR pulse, no READ_VALID, word @2 unchanged.
  - Word load @64 → READ_VALID and ERROR together, READ_DATA=0.
  - Byte load @63 → valid, no error.
- Reset mid-operation:
  - Assert rst 10 cycles into INIT → outputs reset immediately; on release a full 32-cycle INIT runs.
  - Assert rst in the same cycle a load is accepted in IDLE → no READ_VALID emerges and all data reads 0 after re-init.
